// File: rtl/mpu6050_target_pkg.sv
// Shared definitions for the MPU-6050 I2C target emulation.
// Contents: register address map, reset values, FSM state encoding,
// 112-bit sample record and small helper functions.
// Optional feature macro: MPU6050_INT_EN (INT_ENABLE / INT_STATUS registers).
package mpu6050_target_pkg;

  localparam logic [6:0] A_SMPLRT_DIV   = 7'h19;
  localparam logic [6:0] A_CONFIG       = 7'h1A;
  localparam logic [6:0] A_GYRO_CONFIG  = 7'h1B;
  localparam logic [6:0] A_ACCEL_CONFIG = 7'h1C;
  localparam logic [6:0] A_INT_ENABLE   = 7'h38;
  localparam logic [6:0] A_INT_STATUS   = 7'h3A;
  localparam logic [6:0] A_SAMPLE_FIRST = 7'h3B;
  localparam logic [6:0] A_SAMPLE_LAST  = 7'h48;
  localparam logic [6:0] A_PWR_MGMT_1   = 7'h6B;
  localparam logic [6:0] A_WHO_AM_I     = 7'h75;

  localparam int unsigned SAMPLE_BYTES  = 14;
  localparam int unsigned PWR_SLEEP_BIT = 6;

  localparam logic [7:0] RST_CFG        = 8'h00;
  localparam logic [7:0] RST_PWR_MGMT_1 = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_PTR,
    ST_WR_ACK,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_ACK
  } state_e;

  // MSB word first, matching the register order 0x3B..0x48
  typedef struct packed {
    logic [15:0] accel_x;
    logic [15:0] accel_y;
    logic [15:0] accel_z;
    logic [15:0] temp;
    logic [15:0] gyro_x;
    logic [15:0] gyro_y;
    logic [15:0] gyro_z;
  } sample_t;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Byte idx (0 = ACCEL_XOUT_H) of a sample record
  function automatic logic [7:0] sample_byte(input sample_t s, input logic [3:0] idx);
    logic [111:0] flat;
    logic [7:0]   b;
    flat = s;
    b    = '0;
    for (int unsigned i = 0; i < SAMPLE_BYTES; i++) begin
      if (idx == 4'(i)) b = flat[8*(SAMPLE_BYTES-1-i) +: 8];
    end
    return b;
  endfunction

endpackage

// File: rtl/mpu6050_i2c_target_if.sv
// I2C pin bundle between the bus (initiator side) and the target.
//   scl_i, sda_i : pin levels seen by the target (asynchronous)
//   sda_oe       : 1 = target pulls SDA low (open-drain)
interface mpu6050_i2c_target_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_bus_cond.sv
// I2C input conditioning: 2-flop synchronizers, 3-sample majority filter,
// SCL edge strobes and START/STOP strobes.
//   clk, resetn        : system clock, async active-low reset
//   scl_i, sda_i       : raw pin inputs
//   sda_f              : filtered SDA level
//   scl_rise, scl_fall : one-cycle strobes on filtered SCL edges
//   start_det, stop_det: one-cycle strobes for START / STOP
module i2c_bus_cond
  import mpu6050_target_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_f,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic [2:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
  logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;

  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    scl_filt_d = maj3(scl_hist_q);
    sda_filt_d = maj3(sda_hist_q);
    scl_prev_d = scl_filt_q;
    sda_prev_d = sda_filt_q;
  end

  // Bus idles high, so everything resets to 1
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      scl_filt_q <= scl_filt_d;
      sda_filt_q <= sda_filt_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign sda_f     = sda_filt_q;
  assign scl_rise  =  scl_filt_q & ~scl_prev_q;
  assign scl_fall  = ~scl_filt_q &  scl_prev_q;
  // SDA edge qualified by SCL being high on both sides of the edge
  assign start_det = scl_filt_q & scl_prev_q &  sda_prev_q & ~sda_filt_q;
  assign stop_det  = scl_filt_q & scl_prev_q & ~sda_prev_q &  sda_filt_q;

endmodule

// File: rtl/mpu6050_i2c_target.sv
// MPU-6050 register-subset I2C target.
//   clk, resetn  : 100 MHz clock, async active-low reset
//   bus          : I2C pins (slave modport: scl_i, sda_i in; sda_oe out)
//   sample_data  : ACCEL_X..GYRO_Z, 16 bits each, MSB word first
//   sample_valid : one-cycle strobe capturing sample_data into the shadow
//   sleep_o      : PWR_MGMT_1[6]
//   busy_o       : high from an addressed START until STOP
//   int_o        : INT_ENABLE[0] & DATA_RDY (only with MPU6050_INT_EN)
// Optional feature macro: MPU6050_INT_EN.
module mpu6050_i2c_target
  import mpu6050_target_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
  input  logic                 clk,
  input  logic                 resetn,
  mpu6050_i2c_target_if.slave  bus,
  input  logic [111:0]         sample_data,
  input  logic                 sample_valid,
  output logic                 sleep_o,
  output logic                 busy_o
`ifdef MPU6050_INT_EN
  ,
  output logic                 int_o
`endif
);

  logic sda_f, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_cond u_cond (
    .clk       (clk),
    .resetn    (resetn),
    .scl_i     (bus.scl_i),
    .sda_i     (bus.sda_i),
    .sda_f     (sda_f),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic [6:0] tx_q, tx_d;
  logic [6:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       mack_q, mack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_en, load_rd;
  logic [7:0] rd_data;

  logic [7:0] smplrt_q, smplrt_d, cfg_q, cfg_d, gyro_q, gyro_d, accel_q, accel_d;
  logic [7:0] pwr_q, pwr_d;
  sample_t    shadow_q, shadow_d, live_q, live_d;
  logic       pending_q, pending_d;
  logic       copy;

`ifdef MPU6050_INT_EN
  logic int_en_q, int_en_d, data_rdy_q, data_rdy_d, rd_status_q, rd_status_d;
  logic clr_rdy;
`endif

  // Register read mux at the current pointer
  always_comb begin
    rd_data = '0;
    if (ptr_q >= A_SAMPLE_FIRST && ptr_q <= A_SAMPLE_LAST)
      rd_data = sample_byte(live_q, 4'(ptr_q - A_SAMPLE_FIRST));
    case (ptr_q)
      A_SMPLRT_DIV:   rd_data = smplrt_q;
      A_CONFIG:       rd_data = cfg_q;
      A_GYRO_CONFIG:  rd_data = gyro_q;
      A_ACCEL_CONFIG: rd_data = accel_q;
      A_PWR_MGMT_1:   rd_data = pwr_q;
      A_WHO_AM_I:     rd_data = WHO_AM_I_VAL;
`ifdef MPU6050_INT_EN
      A_INT_ENABLE:   rd_data = {7'b0, int_en_q};
      A_INT_STATUS:   rd_data = {7'b0, data_rdy_q};
`endif
      default: ;
    endcase
  end

  // Protocol FSM. Bits are sampled on filtered SCL rise; every SDA drive
  // decision is taken on the filtered SCL fall and lands one clk later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    tx_d     = tx_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    mack_d   = mack_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    wr_en    = 1'b0;
    load_rd  = 1'b0;
`ifdef MPU6050_INT_EN
    clr_rdy     = 1'b0;
    rd_status_d = rd_status_q;
`endif
    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = ST_ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (sh_q[7:1] == I2C_ADDR) begin
              state_d  = ST_ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = sh_q[0];
              busy_d   = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              state_d = ST_RD_DATA;
              load_rd = 1'b1;
            end else begin
              state_d  = ST_WR_PTR;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end
          end
        end
        ST_WR_PTR, ST_WR_DATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (state_q == ST_WR_PTR) begin
              ptr_d = sh_q[6:0];
            end else begin
              wr_en = 1'b1;
              ptr_d = ptr_q + 7'd1;
            end
            state_d  = ST_WR_ACK;
            sda_oe_d = 1'b1;
          end
        end
        ST_WR_ACK: begin
          if (scl_fall) begin
            state_d  = ST_WR_DATA;
            sda_oe_d = 1'b0;
            cnt_d    = '0;
          end
        end
        ST_RD_DATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d  = ST_RD_ACK;
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 7'd1;
`ifdef MPU6050_INT_EN
              clr_rdy  = rd_status_q;
`endif
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_f;
          end else if (scl_fall) begin
            if (!mack_q) begin
              state_d = ST_RD_DATA;
              load_rd = 1'b1;
            end else begin
              state_d  = ST_IDLE;
              sda_oe_d = 1'b0;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    // Byte load shared by the address-ACK and initiator-ACK paths
    if (load_rd) begin
      sda_oe_d = ~rd_data[7];
      tx_d     = rd_data[6:0];
      cnt_d    = '0;
`ifdef MPU6050_INT_EN
      rd_status_d = (ptr_q == A_INT_STATUS);
`endif
    end
  end

  // Register file, shadow/live sample buffers
  always_comb begin
    smplrt_d  = smplrt_q;
    cfg_d     = cfg_q;
    gyro_d    = gyro_q;
    accel_d   = accel_q;
    pwr_d     = pwr_q;
    shadow_d  = shadow_q;
    live_d    = live_q;
    pending_d = pending_q;
`ifdef MPU6050_INT_EN
    int_en_d   = int_en_q;
    data_rdy_d = data_rdy_q;
`endif
    if (wr_en) begin
      case (ptr_q)
        A_SMPLRT_DIV:   smplrt_d = sh_q;
        A_CONFIG:       cfg_d    = sh_q;
        A_GYRO_CONFIG:  gyro_d   = sh_q;
        A_ACCEL_CONFIG: accel_d  = sh_q;
        A_PWR_MGMT_1:   pwr_d    = sh_q;
`ifdef MPU6050_INT_EN
        A_INT_ENABLE:   int_en_d = sh_q[0];
`endif
        default: ;
      endcase
    end
    // Live registers only change between transfers, so a burst never mixes samples
    copy = pending_q & ~busy_q;
    if (copy) begin
      live_d    = shadow_q;
      pending_d = 1'b0;
    end
    // A strobe coinciding with the copy stays pending for the next copy
    if (sample_valid && !pwr_q[PWR_SLEEP_BIT]) begin
      shadow_d  = sample_t'(sample_data);
      pending_d = 1'b1;
    end
`ifdef MPU6050_INT_EN
    if (clr_rdy) data_rdy_d = 1'b0;
    if (copy)    data_rdy_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      mack_q    <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      smplrt_q  <= RST_CFG;
      cfg_q     <= RST_CFG;
      gyro_q    <= RST_CFG;
      accel_q   <= RST_CFG;
      pwr_q     <= RST_PWR_MGMT_1;
      shadow_q  <= '0;
      live_q    <= '0;
      pending_q <= 1'b0;
`ifdef MPU6050_INT_EN
      int_en_q    <= 1'b0;
      data_rdy_q  <= 1'b0;
      rd_status_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      mack_q    <= mack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      smplrt_q  <= smplrt_d;
      cfg_q     <= cfg_d;
      gyro_q    <= gyro_d;
      accel_q   <= accel_d;
      pwr_q     <= pwr_d;
      shadow_q  <= shadow_d;
      live_q    <= live_d;
      pending_q <= pending_d;
`ifdef MPU6050_INT_EN
      int_en_q    <= int_en_d;
      data_rdy_q  <= data_rdy_d;
      rd_status_q <= rd_status_d;
`endif
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign sleep_o    = pwr_q[PWR_SLEEP_BIT];
  assign busy_o     = busy_q;
`ifdef MPU6050_INT_EN
  assign int_o      = int_en_q & data_rdy_q;
`endif

endmodule

// File: tb/tb_mpu6050_i2c_target.sv
// Self-checking bench for mpu6050_i2c_target: bit-banged I2C initiator,
// register access vector table, plus hand-written sequences for
// repeated start, address mismatch, sample coherency, sleep, pointer wrap
// and mid-transfer reset.
`timescale 1ns/1ps
module tb_mpu6050_i2c_target;

  localparam int QP = 100; // quarter SCL period in ns

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         scl_m = 1'b1;
  logic         sda_m = 1'b1;
  logic         sda_line;
  logic [111:0] sample_data = '0;
  logic         sample_valid = 1'b0;
  logic         sleep_o, busy_o;
`ifdef MPU6050_INT_EN
  logic         int_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] rbuf [14];
  logic       mon_en = 1'b0;
  logic       saw_oe = 1'b0;

  mpu6050_i2c_target_if bus ();

  assign sda_line  = sda_m & ~bus.sda_oe;
  assign bus.sda_i = sda_line;
  assign bus.scl_i = scl_m;

  mpu6050_i2c_target #(.I2C_ADDR(7'h68), .WHO_AM_I_VAL(8'h68)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .bus          (bus),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sleep_o      (sleep_o),
    .busy_o       (busy_o)
`ifdef MPU6050_INT_EN
    ,
    .int_o        (int_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mon_en && bus.sda_oe) saw_oe <= 1'b1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic i2c_start();
    if (scl_m == 1'b0) begin
      #QP sda_m = 1'b1;
      #QP scl_m = 1'b1;
      #QP;
    end else begin
      #QP;
    end
    sda_m = 1'b0;
    #QP scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #QP sda_m = 1'b0;
    #QP scl_m = 1'b1;
    #QP sda_m = 1'b1;
    #QP;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      #QP sda_m = b[i];
      #QP scl_m = 1'b1;
      #(2*QP) scl_m = 1'b0;
    end
    #QP sda_m = 1'b1;
    #QP scl_m = 1'b1;
    #QP ack = sda_line;
    #QP scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) begin
      #QP sda_m = 1'b1;
      #QP scl_m = 1'b1;
      #QP d[i] = sda_line;
      #QP scl_m = 1'b0;
    end
    #QP sda_m = nack;
    #QP scl_m = 1'b1;
    #(2*QP) scl_m = 1'b0;
  endtask

  task automatic pulse_sample(input logic [111:0] v);
    @(negedge clk);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic reg_write(input logic [6:0] a, input logic [7:0] d, output logic ok);
    logic k0, k1, k2;
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte({1'b0, a}, k1);
    send_byte(d, k2);
    i2c_stop();
    ok = !k0 && !k1 && !k2;
  endtask

  // Pointer write, repeated START, n-byte read; optional sample strobe after byte pulse_at
  task automatic read_burst(input logic [6:0] a, input int n, input int pulse_at,
                            input logic [111:0] pv, output logic ok);
    logic k0, k1, k2;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte({1'b0, a}, k1);
    i2c_start();
    send_byte(8'hD1, k2);
    for (int i = 0; i < n; i++) begin
      recv_byte(i == n-1, d);
      rbuf[i] = d;
      if (i == pulse_at) pulse_sample(pv);
    end
    i2c_stop();
    ok = !k0 && !k1 && !k2;
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] data;      // write data, or expected read data
    logic       exp_sleep;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic         ok, k0, k1, k2, k3;
    logic [7:0]   d;
    logic [111:0] sa, sb, sc;

    vecs[0]  = '{1'b1, 7'h6B, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 7'h6B, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 7'h19, 8'h5A, 1'b0};
    vecs[3]  = '{1'b0, 7'h19, 8'h5A, 1'b0};
    vecs[4]  = '{1'b1, 7'h1C, 8'h18, 1'b0};
    vecs[5]  = '{1'b0, 7'h1C, 8'h18, 1'b0};
    vecs[6]  = '{1'b1, 7'h75, 8'h12, 1'b0};
    vecs[7]  = '{1'b0, 7'h75, 8'h68, 1'b0};
    vecs[8]  = '{1'b1, 7'h3B, 8'h77, 1'b0};
    vecs[9]  = '{1'b0, 7'h3B, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 7'h38, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 7'h00, 8'h00, 1'b0};

    for (int k = 0; k < 14; k++) begin
      sa[111-8*k -: 8] = 8'(k + 1);
      sb[111-8*k -: 8] = 8'(8'hF1 + k);
    end
    sc = {14{8'h55}};

    // Reset state
    #100;
    check("reset_sda_oe", 32'(bus.sda_oe), 32'h0);
    check("reset_busy",   32'(busy_o),     32'h0);
    check("reset_sleep",  32'(sleep_o),    32'h1);
    resetn = 1'b1;
    #200;

    // WHO_AM_I via repeated START, single byte with NACK
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte(8'h75, k1);
    i2c_start();
    send_byte(8'hD1, k2);
    check("who_ack_addr_w", 32'(k0), 32'h0);
    check("who_ack_ptr",    32'(k1), 32'h0);
    check("who_ack_addr_r", 32'(k2), 32'h0);
    check("who_busy",       32'(busy_o), 32'h1);
    recv_byte(1'b1, d);
    check("who_data", 32'(d), 32'h68);
    #100;
    check("who_oe_after_nack", 32'(bus.sda_oe), 32'h0);
    i2c_stop();
    check("who_busy_after_stop", 32'(busy_o), 32'h0);

    // Address mismatch: NACK and no SDA drive until STOP
    saw_oe = 1'b0;
    mon_en = 1'b1;
    i2c_start();
    send_byte(8'hD2, k0);
    send_byte(8'h75, k1);
    send_byte(8'h00, k2);
    i2c_stop();
    mon_en = 1'b0;
    check("mismatch_nack", 32'(k0), 32'h1);
    check("mismatch_no_drive", 32'(saw_oe), 32'h0);

    // Register access vector table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        reg_write(vecs[i].addr, vecs[i].data, ok);
        check($sformatf("vec%0d_wr_ack", i), 32'(ok), 32'h1);
      end else begin
        read_burst(vecs[i].addr, 1, -1, '0, ok);
        check($sformatf("vec%0d_rd_ack", i), 32'(ok), 32'h1);
        check($sformatf("vec%0d_rd_data", i), 32'(rbuf[0]), 32'(vecs[i].data));
      end
      check($sformatf("vec%0d_sleep", i), 32'(sleep_o), 32'(vecs[i].exp_sleep));
    end

    // Multi-byte write with auto-increment, then burst read back
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte(8'h1A, k1);
    send_byte(8'h11, k2);
    send_byte(8'h22, k3);
    i2c_stop();
    check("mw_acks", 32'({k0, k1, k2, k3}), 32'h0);
    read_burst(7'h19, 4, -1, '0, ok);
    check("mw_rd_ack", 32'(ok), 32'h1);
    check("mw_rd0", 32'(rbuf[0]), 32'h5A);
    check("mw_rd1", 32'(rbuf[1]), 32'h11);
    check("mw_rd2", 32'(rbuf[2]), 32'h22);
    check("mw_rd3", 32'(rbuf[3]), 32'h18);

    // Sample coherency: new sample mid-burst must not appear until after STOP
    pulse_sample(sa);
    #200;
    read_burst(7'h3B, 14, 4, sb, ok);
    check("burst1_ack", 32'(ok), 32'h1);
    for (int k = 0; k < 14; k++)
      check($sformatf("burst1_b%0d", k), 32'(rbuf[k]), 32'(k + 1));
    #200;
    read_burst(7'h3B, 14, -1, '0, ok);
    check("burst2_ack", 32'(ok), 32'h1);
    for (int k = 0; k < 14; k++)
      check($sformatf("burst2_b%0d", k), 32'(rbuf[k]), 32'(8'hF1 + k));

    // Sleep: sample strobes ignored
    reg_write(7'h6B, 8'h40, ok);
    check("sleep_wr_ack", 32'(ok), 32'h1);
    check("sleep_on", 32'(sleep_o), 32'h1);
    pulse_sample(sc);
    #200;
    read_burst(7'h3B, 1, -1, '0, ok);
    check("sleep_sample_kept", 32'(rbuf[0]), 32'hF1);

    // Pointer wrap 0x7F -> 0x00 -> 0x01 on writes
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte(8'h7F, k1);
    send_byte(8'hAA, k2);
    send_byte(8'h55, k3);
    i2c_stop();
    check("wrap_acks", 32'({k0, k1, k2, k3}), 32'h0);
    i2c_start();
    send_byte(8'hD1, k0);
    recv_byte(1'b1, d);
    i2c_stop();
    check("wrap_cur_ack", 32'(k0), 32'h0);
    check("wrap_cur_data", 32'(d), 32'h00);
    read_burst(7'h00, 1, -1, '0, ok);
    check("wrap_reg00", 32'(rbuf[0]), 32'h00);

    // Reset in the middle of a read data bit 0
    reg_write(7'h6B, 8'h00, ok);
    check("pre_reset_wake", 32'(sleep_o), 32'h0);
    i2c_start();
    send_byte(8'hD0, k0);
    send_byte(8'h01, k1);
    i2c_start();
    send_byte(8'hD1, k2);
    #100;
    check("rst_pre_drive", 32'(bus.sda_oe), 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_async_release", 32'(bus.sda_oe), 32'h0);
    #19;
    resetn = 1'b1;
    #QP;
    i2c_stop();
    read_burst(7'h6B, 1, -1, '0, ok);
    check("rst_rd_ack", 32'(ok), 32'h1);
    check("rst_pwr_mgmt", 32'(rbuf[0]), 32'h40);
    check("rst_sleep", 32'(sleep_o), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
